// File: rtl/micro_sequencer.sv
// Micro-engine sequencer: walks FETCH/DECODE/EXECUTE1/EXECUTE2, owns the micro
// program counter, the micro-code fetch handshake and the retired-instruction count.
module micro_sequencer #(
    parameter int UPC_WIDTH   = 10,
    parameter int CNT_WIDTH   = 16,
    parameter int STATE_WIDTH = 3
) (
    input  logic                   sys_clk,
    input  logic                   sys_reset,
    input  logic                   start,
    input  logic [UPC_WIDTH-1:0]   start_addr,
    input  logic                   halt_req,
    output logic                   ucode_req,
    output logic [UPC_WIDTH-1:0]   ucode_addr,
    input  logic                   ucode_ack,
    output logic                   mdecode_load,
    input  logic                   is_branch,
    input  logic [UPC_WIDTH-1:0]   branch_target,
    input  logic                   branch_cond,
    output logic [STATE_WIDTH-1:0] cpu_state,
    output logic [UPC_WIDTH-1:0]   upc,
    output logic [CNT_WIDTH-1:0]   instr_count,
    output logic                   halted
);

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE     = STATE_WIDTH'(0),
        FETCH    = STATE_WIDTH'(1),
        DECODE   = STATE_WIDTH'(2),
        EXECUTE1 = STATE_WIDTH'(3),
        EXECUTE2 = STATE_WIDTH'(4),
        HALT     = STATE_WIDTH'(5)
    } state_t;

    state_t               state_q, state_d;
    logic [UPC_WIDTH-1:0] upc_q, upc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 halt_pend_q, halt_pend_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q     <= IDLE;
            upc_q       <= '0;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            upc_q       <= upc_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        upc_d       = upc_q;
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    upc_d   = start_addr;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (halt_req) halt_pend_d = 1'b1;
                if (ucode_ack) state_d = DECODE;
            end
            DECODE: begin
                if (halt_req) halt_pend_d = 1'b1;
                state_d = EXECUTE1;
            end
            EXECUTE1: begin
                if (halt_req) halt_pend_d = 1'b1;
                state_d = EXECUTE2;
            end
            EXECUTE2: begin
                // Instruction boundary: resolve branch, retire, and honour any halt.
                upc_d = (is_branch && branch_cond) ? branch_target : upc_q + 1'b1;
                cnt_d = sat_inc(cnt_q);
                if (halt_pend_q || halt_req) begin
                    state_d     = HALT;
                    halt_pend_d = 1'b0;
                end else begin
                    state_d = FETCH;
                end
            end
            HALT: begin
                if (start) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are the state register or pure decodes of it.
    assign cpu_state    = state_q;
    assign ucode_req    = (state_q == FETCH);
    assign mdecode_load = (state_q == DECODE);
    assign halted       = (state_q == HALT);
    assign upc          = upc_q;
    assign ucode_addr   = upc_q;
    assign instr_count  = cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: expectations queued per step, popped and
// compared against DUT outputs sampled on the falling clock edge.
module tb_micro_sequencer;

    localparam int UW = 10;
    localparam int CW = 16;
    localparam int SW = 3;

    logic          sys_clk;
    logic          sys_reset;
    logic          start;
    logic [UW-1:0] start_addr;
    logic          halt_req;
    logic          ucode_req;
    logic [UW-1:0] ucode_addr;
    logic          ucode_ack;
    logic          mdecode_load;
    logic          is_branch;
    logic [UW-1:0] branch_target;
    logic          branch_cond;
    logic [SW-1:0] cpu_state;
    logic [UW-1:0] upc;
    logic [CW-1:0] instr_count;
    logic          halted;

    micro_sequencer #(.UPC_WIDTH(UW), .CNT_WIDTH(CW), .STATE_WIDTH(SW)) dut (
        .sys_clk      (sys_clk),
        .sys_reset    (sys_reset),
        .start        (start),
        .start_addr   (start_addr),
        .halt_req     (halt_req),
        .ucode_req    (ucode_req),
        .ucode_addr   (ucode_addr),
        .ucode_ack    (ucode_ack),
        .mdecode_load (mdecode_load),
        .is_branch    (is_branch),
        .branch_target(branch_target),
        .branch_cond  (branch_cond),
        .cpu_state    (cpu_state),
        .upc          (upc),
        .instr_count  (instr_count),
        .halted       (halted)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef enum int {S_STATE, S_UPC, S_ADDR, S_CNT, S_HALT, S_REQ, S_LOAD} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;

    function automatic logic [31:0] observe(input sel_t s);
        case (s)
            S_STATE: return 32'(cpu_state);
            S_UPC:   return 32'(upc);
            S_ADDR:  return 32'(ucode_addr);
            S_CNT:   return 32'(instr_count);
            S_HALT:  return 32'(halted);
            S_REQ:   return 32'(ucode_req);
            default: return 32'(mdecode_load);
        endcase
    endfunction

    task automatic expect_val(input string tag, input sel_t sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    // From an observed FETCH cycle: run one instruction with immediate ack.
    task automatic run_instr(input logic br, input logic cond, input logic [UW-1:0] tgt,
                             input logic [UW-1:0] next_addr, input string tag);
        ucode_ack = 1'b1;
        tick();
        ucode_ack = 1'b0;
        expect_val({tag, "_dec"}, S_STATE, 32'd2);
        expect_val({tag, "_load"}, S_LOAD, 32'd1);
        check_all();
        tick();
        expect_val({tag, "_ex1"}, S_STATE, 32'd3);
        check_all();
        is_branch     = br;
        branch_cond   = cond;
        branch_target = tgt;
        tick();
        expect_val({tag, "_ex2"}, S_STATE, 32'd4);
        check_all();
        tick();
        is_branch     = 1'b0;
        branch_cond   = 1'b0;
        branch_target = '0;
        exp_cnt++;
        expect_val({tag, "_fetch"}, S_STATE, 32'd1);
        expect_val({tag, "_addr"}, S_ADDR, 32'(next_addr));
        expect_val({tag, "_upc"}, S_UPC, 32'(next_addr));
        expect_val({tag, "_cnt"}, S_CNT, 32'(exp_cnt));
        check_all();
    endtask

    initial begin
        logic [SW-1:0] trace [8];
        trace = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};

        sys_reset = 1'b1; start = 1'b0; start_addr = '0; halt_req = 1'b0;
        ucode_ack = 1'b0; is_branch = 1'b0; branch_target = '0; branch_cond = 1'b0;
        tick();
        tick();
        expect_val("rst_state", S_STATE, 32'd0);
        expect_val("rst_upc", S_UPC, 32'd0);
        expect_val("rst_cnt", S_CNT, 32'd0);
        expect_val("rst_halted", S_HALT, 32'd0);
        expect_val("rst_req", S_REQ, 32'd0);
        expect_val("rst_load", S_LOAD, 32'd0);
        check_all();
        sys_reset = 1'b0;

        // Start from IDLE
        start = 1'b1; start_addr = 10'h010;
        tick();
        start = 1'b0;
        expect_val("start_state", S_STATE, 32'd1);
        expect_val("start_req", S_REQ, 32'd1);
        expect_val("start_addr", S_ADDR, 32'h010);
        check_all();

        // Fetch stalled three cycles, ack on the fourth FETCH cycle
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            expect_val($sformatf("trace%0d_state", i), S_STATE, 32'(trace[i]));
            expect_val($sformatf("trace%0d_load", i), S_LOAD, 32'(trace[i] == 3'd2));
            expect_val($sformatf("trace%0d_req", i), S_REQ, 32'(trace[i] == 3'd1));
            if (i == 7) begin
                expect_val("stall_upc", S_UPC, 32'h011);
                expect_val("stall_cnt", S_CNT, 32'd1);
            end
            check_all();
            ucode_ack = (i == 3);
        end
        exp_cnt = 1;

        run_instr(1'b1, 1'b1, 10'h3F0, 10'h3F0, "br_taken");
        run_instr(1'b1, 1'b0, 10'h155, 10'h3F1, "br_nottaken");
        run_instr(1'b0, 1'b1, 10'h200, 10'h3F2, "br_notbranch");
        run_instr(1'b1, 1'b1, 10'h3FF, 10'h3FF, "to_3ff");
        run_instr(1'b0, 1'b0, 10'h000, 10'h000, "wrap");

        // Halt requested for one cycle during DECODE
        ucode_ack = 1'b1;
        tick();
        ucode_ack = 1'b0;
        halt_req  = 1'b1;
        expect_val("halt_dec", S_STATE, 32'd2);
        check_all();
        tick();
        halt_req = 1'b0;
        expect_val("halt_ex1", S_STATE, 32'd3);
        check_all();
        tick();
        expect_val("halt_ex2", S_STATE, 32'd4);
        check_all();
        tick();
        exp_cnt++;
        expect_val("halt_state", S_STATE, 32'd5);
        expect_val("halt_flag", S_HALT, 32'd1);
        expect_val("halt_upc", S_UPC, 32'h001);
        expect_val("halt_cnt", S_CNT, 32'(exp_cnt));
        expect_val("halt_req_out", S_REQ, 32'd0);
        check_all();
        halt_req = 1'b1; ucode_ack = 1'b1;
        tick();
        tick();
        halt_req = 1'b0; ucode_ack = 1'b0;
        expect_val("hold_state", S_STATE, 32'd5);
        expect_val("hold_upc", S_UPC, 32'h001);
        expect_val("hold_cnt", S_CNT, 32'(exp_cnt));
        check_all();

        // Resume ignores start_addr
        start = 1'b1; start_addr = 10'h100;
        tick();
        start = 1'b0;
        expect_val("resume_state", S_STATE, 32'd1);
        expect_val("resume_addr", S_ADDR, 32'h001);
        expect_val("resume_halted", S_HALT, 32'd0);
        check_all();

        // Reset in EXECUTE1 aborts the instruction
        ucode_ack = 1'b1;
        tick();
        ucode_ack = 1'b0;
        tick();
        expect_val("abort_ex1", S_STATE, 32'd3);
        check_all();
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        expect_val("abort_state", S_STATE, 32'd0);
        expect_val("abort_cnt", S_CNT, 32'd0);
        expect_val("abort_upc", S_UPC, 32'd0);
        check_all();
        tick();
        expect_val("idle_stay", S_STATE, 32'd0);
        check_all();

        // halt_req in IDLE is ignored; next instruction returns to FETCH
        halt_req = 1'b1; start = 1'b1; start_addr = 10'h020;
        tick();
        halt_req = 1'b0; start = 1'b0;
        expect_val("idle_halt_state", S_STATE, 32'd1);
        expect_val("idle_halt_addr", S_ADDR, 32'h020);
        check_all();
        exp_cnt = 0;
        run_instr(1'b0, 1'b0, 10'h000, 10'h021, "after_idle_halt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Top-level micro-engine controller: drives the `cpu_state` bus consumed by the decode register stage and the micro register file (EXECUTE1/EXECUTE2 sequencing).
- Owns the micro program counter (upc) and the fetch handshake to micro-code storage.
- Issues the decode-register load strobe and resolves branches at instruction end.
- Provides start/halt/resume control and an instruction counter.

Parameters:
- UPC_WIDTH, 10, micro program counter / branch target width (matches branch_target field).
- CNT_WIDTH, 16, retired-instruction counter width.
- STATE_WIDTH, 3, `cpu_state` width, equal to $clog2(`CPU_STATES).

Ports:
- sys_clk  in  1  system clock.
- sys_reset  in  1  synchronous active-high reset.
- start  in  1  begin execution from IDLE, or resume from HALT.
- start_addr  in  UPC_WIDTH  initial upc, loaded on start from IDLE.
- halt_req  in  1  request halt at next instruction boundary.
- ucode_req  out  1  micro-code fetch request.
- ucode_addr  out  UPC_WIDTH  fetch address; always equals upc.
- ucode_ack  in  1  fetch data valid; decoder inputs are valid from this cycle on.
- mdecode_load  out  1  one-cycle strobe: decode register captures decoder outputs.
- is_branch  in  1  registered branch flag from the decode register.
- branch_target  in  UPC_WIDTH  registered branch target.
- branch_cond  in  1  branch condition (ALU flag); 1 = taken.
- cpu_state  out  STATE_WIDTH  current state, broadcast to datapath.
- upc  out  UPC_WIDTH  micro program counter.
- instr_count  out  CNT_WIDTH  retired-instruction count.
- halted  out  1  high while in HALT.

Behaviour:
- **Connection.** The port list is the decided interface. sys_clk is the single clock. sys_reset is synchronous and active-high.
- **Reset.** On sys_reset, at the clock edge:
  - cpu_state=IDLE, upc=0, instr_count=0, halted=0, ucode_req=0, mdecode_load=0.
  - The halt-pending flag is cleared.
  - Reset asserted in any state, including mid-fetch, aborts the instruction with no upc or count update.
- **State encoding** (`defines.vh` values): IDLE=0, FETCH=1, DECODE=2, EXECUTE1=3, EXECUTE2=4, HALT=5. cpu_state is the state register itself (registered, no decode delay).
- **IDLE**
  - start=1: upc<=start_addr, go to FETCH.
  - halt_req is ignored.
- **FETCH**
  - ucode_req=1 for exactly the cycles cpu_state==FETCH.
  - ucode_addr=upc throughout.
  - Wait in FETCH until ucode_ack=1, then go to DECODE.
  - Ack in the first FETCH cycle is legal and gives a 1-cycle fetch.
- **DECODE**
  - mdecode_load=1 for this single cycle.
  - The decode register captures at the edge ending DECODE.
  - Next state is EXECUTE1.
- **EXECUTE1**
  - One cycle, no sequencer action.
  - The register file latches its select and write data.
  - Next state is EXECUTE2.
- **EXECUTE2**
  - Instruction boundary; is_branch, branch_cond and branch_target are sampled this cycle.
  - upc update: if is_branch&&branch_cond, upc<=branch_target; else upc<=upc+1, modulo 2^UPC_WIDTH (1023 wraps to 0).
  - instr_count<=instr_count+1, saturating at all-ones.
  - If halt is pending (halt_req now, or latched earlier): go to HALT and clear the pending flag. Otherwise go to FETCH.
- **Halt-pending flag.**
  - Set by halt_req=1 in FETCH, DECODE or EXECUTE1.
  - Held until consumed in EXECUTE2.
  - A halt never interrupts an instruction.
- **HALT**
  - halted=1; upc, instr_count and all other state are held.
  - start=1: halted<=0, go to FETCH at the current upc. start_addr is ignored.
  - halt_req is ignored.
- **Ignored inputs.**
  - start outside IDLE/HALT has no effect.
  - ucode_ack outside FETCH has no effect.
- **Throughput.** Minimum 4 cycles per instruction (FETCH, DECODE, EXECUTE1, EXECUTE2); each FETCH wait cycle adds 1.
- **Output timing.** All outputs are registered or pure decodes of the state register. There is no combinational path from inputs to outputs.

Test Plan:
1. **Reset and start.** Reset → all outputs 0, cpu_state=0. Then start=1, start_addr=0x010 → next cycle cpu_state=1, ucode_req=1, ucode_addr=0x010.
2. **Sequence with fetch stall.** Ack held off 3 cycles, then asserted → state trace 1,1,1,1,2,3,4,1. mdecode_load high only in state 2. upc becomes 0x011 and instr_count 1 after EXECUTE2.
3. **Taken branch.** Ack immediately; is_branch=1, branch_cond=1, branch_target=0x3F0 in EXECUTE2 → next FETCH ucode_addr=0x3F0.
4. **Not-taken branch.** Repeat scenario 3 with branch_cond=0 → next FETCH ucode_addr=upc+1.
5. **Wrap.** upc=0x3FF with no branch → next upc=0x000.
6. **Halt and resume.**
   - halt_req pulsed 1 cycle during DECODE → instruction completes, cpu_state=5, halted=1, upc held.
   - start_addr=0x100 with start=1 → FETCH at the held upc, not 0x100.
   - Reset asserted in EXECUTE1 → IDLE, count 0, no upc update.
